// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_ctrl_pkg                                                  |
// | Shared types and sizes for the branch redirect controller.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package branch_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int QDEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRACK   = 2'd1,
        ST_RECOVER = 2'd2
    } brc_state_t;

    // One in-flight branch: its prediction and the PC to use if that prediction was wrong.
    typedef struct packed {
        logic            pred;
        logic [XLEN-1:0] alt_pc;
    } brc_entry_t;

endpackage
`default_nettype wire

// File: rtl/branch_inflight_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_inflight_fifo                                             |
// | In-order queue of unresolved branches; flush empties it at once. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module branch_inflight_fifo
    import branch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  brc_entry_t i_push_data,
    input  logic       i_pop,
    input  logic       i_flush,
    output logic       o_full,
    output logic       o_empty,
    output brc_entry_t o_head
);

    localparam int c_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    brc_entry_t           r_mem [QDEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic                 w_do_push;
    logic                 w_do_pop;
    logic [c_PTR_W-1:0]   w_wr_next;
    logic [c_PTR_W-1:0]   w_rd_next;

    assign o_full    = (r_count == (c_PTR_W+1)'(QDEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];

    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;

    assign w_wr_next = (r_wr_ptr == c_PTR_W'(QDEPTH-1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
    assign w_rd_next = (r_rd_ptr == c_PTR_W'(QDEPTH-1)) ? '0 : r_rd_ptr + c_PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= r_count + {{c_PTR_W{1'b0}}, w_do_push} - {{c_PTR_W{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_redirect_ctrl                                             |
// | Tracks in-flight branches, issues fetch redirects and flushes.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            d_valid,
    input  logic            d_is_branch,
    input  logic            d_pred_take,
    input  logic [XLEN-1:0] d_target,
    input  logic [XLEN-1:0] d_pc_plus4,
    input  logic            e_resolve,
    input  logic            e_taken,
    input  logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_f1_f2_ppreg,
    output logic            flush_f2_d_ppreg,
    output logic            flush_d_e_ppreg,
    output logic            pred_update_valid,
    output logic            pred_update_taken,
    output logic            stall_req
);

    brc_state_t r_state;
    brc_state_t w_state_next;

    logic       w_dec_branch;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    brc_entry_t w_head;
    brc_entry_t w_push_entry;
    logic       w_resolve;
    logic       w_mispredict;
    logic       w_push;
    logic       w_pred_redirect;

    assign w_dec_branch = d_valid & d_is_branch;
    assign w_resolve    = e_resolve & ~w_fifo_empty;
    assign w_mispredict = w_resolve & (w_head.pred != e_taken);

    assign stall_req    = ~rst & w_fifo_full & w_dec_branch & ~w_resolve;

    // Decode is wrong-path during recovery, and a mispredict this cycle squashes it too.
    assign w_push = w_dec_branch & ~stall & ~stall_req &
                    (r_state != ST_RECOVER) & ~w_mispredict;

    assign w_pred_redirect     = w_push & d_pred_take;
    assign w_push_entry.pred   = d_pred_take;
    assign w_push_entry.alt_pc = d_pred_take ? d_pc_plus4 : d_target;

    branch_inflight_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_resolve),
        .i_flush     (w_mispredict),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_mispredict) begin
            w_state_next = ST_RECOVER;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_push) begin
                        w_state_next = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    // Not full while tracking means exactly one entry, so this pop drains it.
                    if (w_resolve && !w_push && !w_fifo_full) begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_RECOVER: w_state_next = ST_IDLE;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
            flush_f1_f2_ppreg <= 1'b0;
            flush_f2_d_ppreg  <= 1'b0;
            flush_d_e_ppreg   <= 1'b0;
            pred_update_valid <= 1'b0;
            pred_update_taken <= 1'b0;
        end else begin
            redirect_valid    <= w_mispredict | w_pred_redirect;
            redirect_pc       <= w_mispredict    ? w_head.alt_pc :
                                 w_pred_redirect ? d_target      : '0;
            flush_f1_f2_ppreg <= w_mispredict | w_pred_redirect;
            flush_f2_d_ppreg  <= w_mispredict | w_pred_redirect;
            flush_d_e_ppreg   <= w_mispredict;
            pred_update_valid <= w_resolve;
            pred_update_taken <= w_resolve & e_taken;
        end
    end

endmodule
`default_nettype wire
